// File: rtl/zorro_autoconfig.sv
// Zorro II AutoConfig responder for the IDE card: serves the configuration
// nibbles in $E8xxxx, captures the 128 KB base address and qualifies IDE
// accesses for the downstream decode block.
//
// state  | meaning
// UNCONF | waiting for the OS to configure us (responds in $E8xxxx)
// CONFIG | base address assigned, card decodes its window
// SHUTUP | OS told us to stay off the bus until the next reset
module zorro_autoconfig #(
  parameter logic [15:0] MANUF_ID = 16'h07DB,
  parameter logic [7:0]  PROD_ID  = 8'h05,
  parameter logic [31:0] SERIAL   = 32'h0000_0001,
  parameter logic [15:0] DIAG_VEC = 16'h4000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] ADDR,
  input  logic        AS_n,
  input  logic        UDS_n,
  input  logic        RW,
  input  logic [3:0]  DIN,
  input  logic        CFGIN_n,
  input  logic        ide_enable,
  output logic [3:0]  DOUT,
  output logic        DOE,
  output logic        CFGOUT_n,
  output logic        ide_access,
  output logic        configured
);

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    CONFIG = 2'd1,
    SHUTUP = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] base_hi, base_hi_nxt;
  logic [2:0] base_lo, base_lo_nxt;
  logic       wr_done, wr_done_nxt;
  logic       cfgout_q;
  logic       cfg_hit;
  logic       commit;
  logic       unused_addr;

  // Low address bits above the register window play no part in decoding.
  assign unused_addr = ^ADDR[15:8];

  assign cfg_hit = (state == UNCONF) && ide_enable && !CFGIN_n && !AS_n &&
                   (ADDR[23:16] == 8'hE8);
  assign commit  = cfg_hit && !RW && !UDS_n && !wr_done;

  // State, base and one-commit-per-bus-cycle tracking registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= UNCONF;
      base_hi <= 4'h0;
      base_lo <= 3'h0;
      wr_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      base_hi <= base_hi_nxt;
      base_lo <= base_lo_nxt;
      wr_done <= wr_done_nxt;
    end
  end

  // Next-state: commits decode the register offset; wr_done re-arms when AS_n ends the cycle.
  always_comb begin
    state_nxt   = state;
    base_hi_nxt = base_hi;
    base_lo_nxt = base_lo;
    wr_done_nxt = wr_done;
    if (AS_n) wr_done_nxt = 1'b0;
    if (commit) begin
      wr_done_nxt = 1'b1;
      case (ADDR[7:1])
        7'h24: begin
          base_hi_nxt = DIN;
          state_nxt   = CONFIG;
        end
        7'h25: base_lo_nxt = DIN[3:1];
        7'h26: state_nxt   = SHUTUP;
        default: ;
      endcase
    end
  end

  // Chain output drops one clock after we leave UNCONF.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                 cfgout_q <= 1'b1;
    else if (state != UNCONF)  cfgout_q <= 1'b0;
  end

  // Configuration ROM nibbles; most are stored inverted on the bus.
  always_comb begin
    DOUT = 4'hF;
    if (!RESET) begin
      case (ADDR[7:1])
        7'h00: DOUT = 4'hD;
        7'h01: DOUT = 4'h2;
        7'h02: DOUT = ~PROD_ID[7:4];
        7'h03: DOUT = ~PROD_ID[3:0];
        7'h08: DOUT = ~MANUF_ID[15:12];
        7'h09: DOUT = ~MANUF_ID[11:8];
        7'h0A: DOUT = ~MANUF_ID[7:4];
        7'h0B: DOUT = ~MANUF_ID[3:0];
        7'h0C: DOUT = ~SERIAL[31:28];
        7'h0D: DOUT = ~SERIAL[27:24];
        7'h0E: DOUT = ~SERIAL[23:20];
        7'h0F: DOUT = ~SERIAL[19:16];
        7'h10: DOUT = ~SERIAL[15:12];
        7'h11: DOUT = ~SERIAL[11:8];
        7'h12: DOUT = ~SERIAL[7:4];
        7'h13: DOUT = ~SERIAL[3:0];
        7'h14: DOUT = ~DIAG_VEC[15:12];
        7'h15: DOUT = ~DIAG_VEC[11:8];
        7'h16: DOUT = ~DIAG_VEC[7:4];
        7'h17: DOUT = ~DIAG_VEC[3:0];
        7'h20: DOUT = 4'h0;
        7'h21: DOUT = 4'h0;
        default: DOUT = 4'hF;
      endcase
    end
  end

  assign DOE        = !RESET && cfg_hit && RW;
  assign configured = (state == CONFIG);
  assign CFGOUT_n   = ide_enable ? cfgout_q : CFGIN_n;
  // ADDR[16] is deliberately left out so both 64 KB halves of the window match.
  assign ide_access = !RESET && configured && ide_enable && !AS_n &&
                      (ADDR[23:17] == {base_hi, base_lo});

endmodule
